// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control unit: Moore state sequencer for a shared-memory datapath.
// Optional: define MC_CTRL_BNE_EN to decode bne (opcode 6'h05) into the BRANCH state.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] funct_alu;
  logic       funct_ok;
  logic       op_ok;
  logic       taken;
  logic       pc_write;
  logic       branch;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h2a:   funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    op_ok   = 1'b1;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      op_ok   = 1'b0;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_EXEC:     state_d = S_R_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

`ifdef MC_CTRL_BNE_EN
  assign taken = (opcode == OP_BNE) ? ~zero : zero;
`else
  assign taken = zero;
`endif

  // Moore decode of the current state; reset masks every enable and pulse asynchronously.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    pc_source  = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal    = ~op_ok;
        instr_done = ~op_ok;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_alu;
        illegal   = ~funct_ok;
      end
      S_R_WB: begin
        alu_ctrl   = funct_alu;
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = ALU_SUB;
        pc_source  = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    pc_en = pc_write | (branch & taken);
    if (!rst_n) begin
      pc_en      = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl; checks state sequence and masked control vectors per cycle.
// Honours MC_CTRL_BNE_EN for the bne scenario.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  logic [17:0] ctrlVec;

  int checks = 0;
  int errors = 0;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_source(pc_source),
    .state(state), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // pc_en iord mem_read mem_write ir_write reg_dst mem_to_reg reg_write srcA srcB[2] alu[3] pcsrc[2] done illegal
  assign ctrlVec = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                    alu_src_a, alu_src_b, alu_ctrl, pc_source, instr_done, illegal};

  localparam logic [17:0] E_RST   = 18'b0_0_0_0_0_0_0_0_0_01_010_00_0_0;
  localparam logic [17:0] M_FULL  = 18'b1_1_1_1_1_0_0_1_1_11_111_11_1_1;
  localparam logic [17:0] E_FETCH = 18'b1_0_1_0_1_0_0_0_0_01_010_00_0_0;
  localparam logic [17:0] E_DEC   = 18'b0_0_0_0_0_0_0_0_0_11_010_00_0_0;
  localparam logic [17:0] E_DECI  = 18'b0_0_0_0_0_0_0_0_0_11_010_00_1_1;
  localparam logic [17:0] M_ALU   = 18'b1_0_1_1_1_0_0_1_1_11_111_00_1_1;
  localparam logic [17:0] E_MADDR = 18'b0_0_0_0_0_0_0_0_1_10_010_00_0_0;
  localparam logic [17:0] E_MRD   = 18'b0_1_1_0_0_0_0_0_0_00_000_00_0_0;
  localparam logic [17:0] M_MEM   = 18'b1_1_1_1_1_0_0_1_0_00_000_00_1_1;
  localparam logic [17:0] E_MWB   = 18'b0_0_0_0_0_0_1_1_0_00_000_00_1_0;
  localparam logic [17:0] M_WB    = 18'b1_0_1_1_1_1_1_1_0_00_000_00_1_1;
  localparam logic [17:0] E_MWR   = 18'b0_1_0_1_0_0_0_0_0_00_000_00_1_0;
  localparam logic [17:0] E_BRT   = 18'b1_0_0_0_0_0_0_0_1_00_110_01_1_0;
  localparam logic [17:0] E_BRN   = 18'b0_0_0_0_0_0_0_0_1_00_110_01_1_0;
  localparam logic [17:0] E_JMP   = 18'b1_0_0_0_0_0_0_0_0_00_000_10_1_0;
  localparam logic [17:0] M_JMP   = 18'b1_0_1_1_1_0_0_1_0_00_000_11_1_1;
  localparam logic [17:0] E_AWB   = 18'b0_0_0_0_0_0_0_1_0_00_000_00_1_0;
  localparam logic [17:0] M_RWB   = 18'b1_0_1_1_1_1_1_1_0_00_111_00_1_1;

  task automatic test_reset();
    rst_n  = 1'b0;
    opcode = 6'h23;
    funct  = 6'h00;
    zero   = 1'b0;
    #100;
    checks++;
    if (state !== 4'd0 || (ctrlVec & M_FULL) !== E_RST) begin
      errors++;
      $display("[TB] FAIL reset_hold: state=%0d ctrl=%b, expected state=0 ctrl=%b", state, ctrlVec & M_FULL, E_RST);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || (ctrlVec & M_FULL) !== E_FETCH) begin
      errors++;
      $display("[TB] FAIL reset_release: state=%0d ctrl=%b, expected state=0 ctrl=%b", state, ctrlVec & M_FULL, E_FETCH);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd1 || (ctrlVec & M_ALU) !== E_DEC) begin
      errors++;
      $display("[TB] FAIL reset_first_decode: state=%0d ctrl=%b, expected state=1 ctrl=%b", state, ctrlVec & M_ALU, E_DEC);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    logic [3:0]  st [6];
    logic [17:0] ex [6];
    logic [17:0] mk [6];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    ex = '{E_FETCH, E_DEC, E_MADDR, E_MRD, E_MWB, E_FETCH};
    mk = '{M_FULL, M_ALU, M_ALU, M_MEM, M_WB, M_FULL};
    opcode = 6'h23;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++;
      if (state !== st[i] || (ctrlVec & mk[i]) !== ex[i]) begin
        errors++;
        $display("[TB] FAIL lw step%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, state, ctrlVec & mk[i], st[i], ex[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [6];
    logic [2:0] alu [6];
    logic [17:0] eEx, eWb;
    fn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};
    alu = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    opcode = 6'h00;
    for (int k = 0; k < 6; k++) begin
      funct = fn[k];
      eEx = {9'b0_0_0_0_0_0_0_0_1, 2'b00, alu[k], 2'b00, 1'b0, (fn[k] == 6'h3f)};
      eWb = {9'b0_0_0_0_0_1_0_1_0, 2'b00, alu[k], 2'b00, 1'b1, 1'b0};
      checks++;
      if (state !== 4'd0 || (ctrlVec & M_FULL) !== E_FETCH) begin
        errors++;
        $display("[TB] FAIL rtype%0d fetch: state=%0d ctrl=%b, expected state=0 ctrl=%b", k, state, ctrlVec & M_FULL, E_FETCH);
      end
      @(posedge clk); #1;
      checks++;
      if (state !== 4'd1 || (ctrlVec & M_ALU) !== E_DEC) begin
        errors++;
        $display("[TB] FAIL rtype%0d decode: state=%0d ctrl=%b, expected state=1 ctrl=%b", k, state, ctrlVec & M_ALU, E_DEC);
      end
      @(posedge clk); #1;
      checks++;
      if (state !== 4'd6 || (ctrlVec & M_ALU) !== eEx) begin
        errors++;
        $display("[TB] FAIL rtype%0d exec: state=%0d ctrl=%b, expected state=6 ctrl=%b", k, state, ctrlVec & M_ALU, eEx);
      end
      @(posedge clk); #1;
      checks++;
      if (state !== 4'd7 || (ctrlVec & M_RWB) !== eWb) begin
        errors++;
        $display("[TB] FAIL rtype%0d rwb: state=%0d ctrl=%b, expected state=7 ctrl=%b", k, state, ctrlVec & M_RWB, eWb);
      end
      @(posedge clk); #1;
    end
    funct = 6'h00;
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z, input logic expTaken, input string name);
    opcode = op;
    zero   = z;
    checks++;
    if (state !== 4'd0 || (ctrlVec & M_FULL) !== E_FETCH) begin
      errors++;
      $display("[TB] FAIL %s fetch: state=%0d ctrl=%b, expected state=0 ctrl=%b", name, state, ctrlVec & M_FULL, E_FETCH);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd1 || (ctrlVec & M_ALU) !== E_DEC) begin
      errors++;
      $display("[TB] FAIL %s decode: state=%0d ctrl=%b, expected state=1 ctrl=%b", name, state, ctrlVec & M_ALU, E_DEC);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd8 || (ctrlVec & M_FULL) !== (expTaken ? E_BRT : E_BRN)) begin
      errors++;
      $display("[TB] FAIL %s branch: state=%0d ctrl=%b, expected state=8 ctrl=%b", name, state, ctrlVec & M_FULL, expTaken ? E_BRT : E_BRN);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("[TB] FAIL %s cpi: state=%0d, expected state=0", name, state);
    end
    zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [3];
    logic [3:0]  st  [3];
    logic [17:0] e2  [3], e3 [3], m2 [3], m3 [3];
    logic [3:0]  s3  [3];
    ops = '{6'h2b, 6'h02, 6'h08};
    st  = '{4'd2, 4'd9, 4'd10};
    e2  = '{E_MADDR, E_JMP, E_MADDR};
    m2  = '{M_ALU, M_JMP, M_ALU};
    s3  = '{4'd5, 4'd0, 4'd11};
    e3  = '{E_MWR, E_FETCH, E_AWB};
    m3  = '{M_MEM, M_FULL, M_WB};
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      @(posedge clk); #1;
      checks++;
      if (state !== 4'd1 || (ctrlVec & M_ALU) !== E_DEC) begin
        errors++;
        $display("[TB] FAIL b2b op%h decode: state=%0d ctrl=%b, expected state=1 ctrl=%b", ops[k], state, ctrlVec & M_ALU, E_DEC);
      end
      @(posedge clk); #1;
      checks++;
      if (state !== st[k] || (ctrlVec & m2[k]) !== e2[k]) begin
        errors++;
        $display("[TB] FAIL b2b op%h step2: state=%0d ctrl=%b, expected state=%0d ctrl=%b", ops[k], state, ctrlVec & m2[k], st[k], e2[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (state !== s3[k] || (ctrlVec & m3[k]) !== e3[k]) begin
        errors++;
        $display("[TB] FAIL b2b op%h step3: state=%0d ctrl=%b, expected state=%0d ctrl=%b", ops[k], state, ctrlVec & m3[k], s3[k], e3[k]);
      end
      if (s3[k] != 4'd0) begin @(posedge clk); #1; end
      checks++;
      if (state !== 4'd0) begin
        errors++;
        $display("[TB] FAIL b2b op%h end: state=%0d, expected state=0", ops[k], state);
      end
    end
  endtask

  task automatic test_illegal(input logic [5:0] op, input string name);
    opcode = op;
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd1 || (ctrlVec & M_ALU) !== E_DECI) begin
      errors++;
      $display("[TB] FAIL %s decode: state=%0d ctrl=%b, expected state=1 ctrl=%b", name, state, ctrlVec & M_ALU, E_DECI);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd0 || (ctrlVec & M_FULL) !== E_FETCH) begin
      errors++;
      $display("[TB] FAIL %s return: state=%0d ctrl=%b, expected state=0 ctrl=%b", name, state, ctrlVec & M_FULL, E_FETCH);
    end
  endtask

  task automatic test_midreset();
    opcode = 6'h23;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    checks++;
    if (state !== 4'd4 || reg_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_pre: state=%0d reg_write=%b, expected state=4 reg_write=1", state, reg_write);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || (ctrlVec & M_FULL) !== E_RST) begin
      errors++;
      $display("[TB] FAIL midreset_hold: state=%0d ctrl=%b, expected state=0 ctrl=%b", state, ctrlVec & M_FULL, E_RST);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || (ctrlVec & M_FULL) !== E_FETCH) begin
      errors++;
      $display("[TB] FAIL midreset_release: state=%0d ctrl=%b, expected state=0 ctrl=%b", state, ctrlVec & M_FULL, E_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_branch(6'h04, 1'b1, 1'b1, "beq_taken");
    test_branch(6'h04, 1'b0, 1'b0, "beq_not_taken");
    test_back_to_back();
`ifdef MC_CTRL_BNE_EN
    test_branch(6'h05, 1'b0, 1'b1, "bne_taken");
    test_branch(6'h05, 1'b1, 1'b0, "bne_not_taken");
`else
    test_illegal(6'h05, "bne_disabled");
`endif
    test_illegal(6'h3f, "illegal_op");
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
